// File: rtl/md_pkg.sv
// Shared types and opcode classification helpers for the HI/LO multiply-divide unit.
package md_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MADD  = 4'd5,
      OP_MADDU = 4'd6,
      OP_MSUB  = 4'd7,
      OP_MSUBU = 4'd8,
      OP_MTHI  = 4'd9,
      OP_MTLO  = 4'd10
   } md_op_t;

   typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

   typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} md_acc_t;

   function automatic logic IS_MUL(input logic [3:0] op);
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic IS_DIV(input logic [3:0] op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   function automatic logic IS_ARITH(input logic [3:0] op);
      return IS_MUL(op) | IS_DIV(op);
   endfunction

   function automatic logic IS_SIGNED(input logic [3:0] op);
      return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
   endfunction

   function automatic md_acc_t ACC_SEL(input logic [3:0] op);
      if (op inside {OP_MADD, OP_MADDU}) return ACC_ADD;
      if (op inside {OP_MSUB, OP_MSUBU}) return ACC_SUB;
      return ACC_NONE;
   endfunction

endpackage

// File: rtl/md_divider_seq.sv
// Restoring shift-subtract divider on operand magnitudes, one quotient bit per cycle,
// followed by one sign-fixup cycle in which o_valid is high.
module md_divider_seq
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_signed_mode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_valid
);

   localparam int unsigned SW = $clog2(WIDTH + 1);

   logic             r_run;
   logic [SW-1:0]    r_step;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_a;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;

   assign w_a_neg = i_signed_mode & i_a[WIDTH-1];
   assign w_b_neg = i_signed_mode & i_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   // r_quo starts as the dividend and shifts out MSB-first while quotient bits fill from the LSB
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_div};
   assign w_ge    = ~w_diff[WIDTH];

   always_ff @(posedge clk) begin
      if (reset || i_abort) begin
         r_run   <= 1'b0;
         r_step  <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_a     <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else if (i_start) begin
         r_run   <= 1'b1;
         r_step  <= SW'(WIDTH);
         r_rem   <= '0;
         r_quo   <= w_a_mag;
         r_div   <= w_b_mag;
         r_a     <= i_a;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_dz    <= (i_b == '0);
      end else if (r_run) begin
         if (r_step != '0) begin
            r_step <= r_step - SW'(1);
            r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo  <= {r_quo[WIDTH-2:0], w_ge};
         end else begin
            r_run <= 1'b0;
         end
      end
   end

   // Signed overflow needs no special case: -(2^(W-1)) wraps back onto itself
   assign o_valid     = r_run && (r_step == '0);
   assign o_quotient  = r_dz ? '1  : (r_neg_q ? -r_quo : r_quo);
   assign o_remainder = r_dz ? r_a : (r_neg_r ? -r_rem : r_rem);

endmodule

// File: rtl/md_unit_iter.sv
// HI/LO multiply-divide unit: fixed-latency multiply/MAC pipeline, iterative divider,
// MTHI/MTLO writes, and exception flush. stall_req holds dependent instructions in ID.
module md_unit_iter
   import md_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MULT_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned DIV_LAT   = WIDTH + 1;
   localparam int unsigned CNT_W_DIV = $clog2(DIV_LAT + 1);
   localparam int unsigned CNT_W_MUL = $clog2(MULT_LAT + 1);
   localparam int unsigned CNT_W     = (CNT_W_DIV > CNT_W_MUL) ? CNT_W_DIV : CNT_W_MUL;

   md_state_t          r_state;
   md_state_t          w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_prod;
   md_acc_t            r_acc;

   logic               w_start_mul;
   logic               w_start_div;
   logic               w_commit_mul;
   logic               w_commit_div;
   logic               w_wr_hi;
   logic               w_wr_lo;
   logic               w_signed;
   logic [2*WIDTH-1:0] w_ext_a;
   logic [2*WIDTH-1:0] w_ext_b;
   logic [2*WIDTH-1:0] w_product;
   logic [2*WIDTH-1:0] w_mul_result;
   logic [WIDTH-1:0]   w_div_q;
   logic [WIDTH-1:0]   w_div_r;
   logic               w_div_valid;

   assign w_signed  = IS_SIGNED(op);
   assign w_ext_a   = w_signed ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
   assign w_ext_b   = w_signed ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
   assign w_product = w_ext_a * w_ext_b;

   // Accumulate against HI/LO as they stand at commit, so MT* issued before accept is included
   always_comb begin
      case (r_acc)
         ACC_ADD: w_mul_result = {r_hi, r_lo} + r_prod;
         ACC_SUB: w_mul_result = {r_hi, r_lo} - r_prod;
         default: w_mul_result = r_prod;
      endcase
   end

   md_divider_seq #(.WIDTH(WIDTH)) u_div (
      .clk          (clk),
      .reset        (reset),
      .i_start      (w_start_div),
      .i_abort      (flush),
      .i_signed_mode(w_signed),
      .i_a          (rs_val),
      .i_b          (rt_val),
      .o_quotient   (w_div_q),
      .o_remainder  (w_div_r),
      .o_valid      (w_div_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_start_mul  = 1'b0;
      w_start_div  = 1'b0;
      w_commit_mul = 1'b0;
      w_commit_div = 1'b0;
      w_wr_hi      = 1'b0;
      w_wr_lo      = 1'b0;
      if (flush) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (IS_MUL(op)) begin
                  w_start_mul  = 1'b1;
                  w_next_state = MUL;
               end else if (IS_DIV(op)) begin
                  w_start_div  = 1'b1;
                  w_next_state = DIV;
               end else if (op == OP_MTHI) begin
                  w_wr_hi = 1'b1;
               end else if (op == OP_MTLO) begin
                  w_wr_lo = 1'b1;
               end
            end
            MUL: begin
               if (r_cnt == '0) begin
                  w_commit_mul = 1'b1;
                  w_next_state = IDLE;
               end
            end
            DIV: begin
               if (w_div_valid) begin
                  w_commit_div = 1'b1;
                  w_next_state = IDLE;
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_prod <= '0;
         r_acc  <= ACC_NONE;
      end else begin
         r_busy <= (w_next_state != IDLE);
         r_done <= w_commit_mul | w_commit_div;
         if (w_start_mul) begin
            r_cnt  <= CNT_W'(MULT_LAT - 1);
            r_prod <= w_product;
            r_acc  <= ACC_SEL(op);
         end else if (flush) begin
            r_cnt <= '0;
         end else if (r_state == MUL && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_commit_mul) begin
            {r_hi, r_lo} <= w_mul_result;
         end
         if (w_commit_div) begin
            r_hi <= w_div_r;
            r_lo <= w_div_q;
         end
         if (w_wr_hi) r_hi <= rs_val;
         if (w_wr_lo) r_lo <= rs_val;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign stall_req = r_busy | IS_ARITH(op);

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed self-checking bench for md_unit_iter at WIDTH=32 and WIDTH=16.
module tb_md_unit_iter;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;

   logic [3:0]  op32, op16;
   logic [31:0] rs32, rt32, hi32, lo32;
   logic [15:0] rs16, rt16, hi16, lo16;
   logic        busy32, stall32, done32;
   logic        busy16, stall16, done16;

   logic        sel16;
   logic        obs_busy, obs_stall, obs_done;
   logic [31:0] obs_hi, obs_lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   md_unit_iter #(.WIDTH(32), .MULT_LAT(5)) dut32 (
      .clk(clk), .reset(reset), .op(op32), .rs_val(rs32), .rt_val(rt32), .flush(flush),
      .busy(busy32), .stall_req(stall32), .done(done32), .hi(hi32), .lo(lo32)
   );

   md_unit_iter #(.WIDTH(16), .MULT_LAT(5)) dut16 (
      .clk(clk), .reset(reset), .op(op16), .rs_val(rs16), .rt_val(rt16), .flush(flush),
      .busy(busy16), .stall_req(stall16), .done(done16), .hi(hi16), .lo(lo16)
   );

   assign obs_busy  = sel16 ? busy16  : busy32;
   assign obs_stall = sel16 ? stall16 : stall32;
   assign obs_done  = sel16 ? done16  : done32;
   assign obs_hi    = sel16 ? {16'h0, hi16} : hi32;
   assign obs_lo    = sel16 ? {16'h0, lo16} : lo32;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit w16, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      if (w16) begin
         op16 = o; rs16 = a[15:0]; rt16 = b[15:0];
      end else begin
         op32 = o; rs32 = a; rt32 = b;
      end
   endtask

   // Issue one arithmetic op, measure busy length, then check the commit cycle
   task automatic run(input string tag, input bit w16, input logic [3:0] o,
                      input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      sel16 = w16;
      drive(w16, o, a, b);
      #1;
      chk({tag, " stall"}, {31'b0, obs_stall}, 32'd1);
      tick();
      drive(w16, OP_NOP, 32'd0, 32'd0);
      #1;
      chk({tag, " busy_on"}, {31'b0, obs_busy}, 32'd1);
      chk({tag, " done_low"}, {31'b0, obs_done}, 32'd0);
      n = 0;
      while (obs_busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      chk({tag, " latency"}, n, exp_lat);
      chk({tag, " done"}, {31'b0, obs_done}, 32'd1);
      chk({tag, " hi"}, obs_hi, exp_hi);
      chk({tag, " lo"}, obs_lo, exp_lo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      reset = 1'b1; flush = 1'b0; sel16 = 1'b0;
      drive(0, OP_NOP, 32'd0, 32'd0);
      drive(1, OP_NOP, 32'd0, 32'd0);
      repeat (3) tick();
      chk("rst hi32", hi32, 32'd0);
      chk("rst lo32", lo32, 32'd0);
      chk("rst busy32", {31'b0, busy32}, 32'd0);
      chk("rst done32", {31'b0, done32}, 32'd0);
      chk("rst hi16", {16'h0, hi16}, 32'd0);
      // reset beats a concurrent MTHI
      drive(0, OP_MTHI, 32'h55, 32'd0);
      tick();
      chk("rst wins", hi32, 32'd0);
      drive(0, OP_NOP, 32'd0, 32'd0);
      reset = 1'b0;
      tick();

      run("mult32",  0, OP_MULT, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run("div32",   0, OP_DIV,  32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu32",  0, OP_DIVU, 32'd7,         32'd2,        33, 32'd1,         32'd3);
      run("divz32",  0, OP_DIVU, 32'h1234,      32'd0,        33, 32'h1234,      32'hFFFF_FFFF);
      run("divov32", 0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,33, 32'd0,         32'h8000_0000);

      run("mult16",  1, OP_MULT, 32'hFFFE, 32'd3,    5,  32'hFFFF, 32'hFFFA);
      run("div16",   1, OP_DIV,  32'hFFF9, 32'd2,    17, 32'hFFFF, 32'hFFFD);
      run("divu16",  1, OP_DIVU, 32'd7,    32'd2,    17, 32'd1,    32'd3);
      run("divz16",  1, OP_DIVU, 32'h1234, 32'd0,    17, 32'h1234, 32'hFFFF);
      run("divov16", 1, OP_DIV,  32'h8000, 32'hFFFF, 17, 32'd0,    32'h8000);
      sel16 = 1'b0;
      tick();

      // MTHI/MTLO then multiply-accumulate chain
      drive(0, OP_MTHI, 32'd0, 32'd0);
      #1;
      chk("mthi stall", {31'b0, stall32}, 32'd0);
      tick();
      chk("mthi hi", hi32, 32'd0);
      chk("mthi busy", {31'b0, busy32}, 32'd0);
      drive(0, OP_MTLO, 32'd10, 32'd0);
      tick();
      chk("mtlo lo", lo32, 32'd10);
      chk("mtlo done", {31'b0, done32}, 32'd0);
      drive(0, OP_NOP, 32'd0, 32'd0);
      run("maddu", 0, OP_MADDU, 32'hFFFF_FFFF, 32'd2, 5, 32'd2, 32'd8);
      run("msub",  0, OP_MSUB,  32'd1,         32'd9, 5, 32'd1, 32'hFFFF_FFFF);
      run("madd",  0, OP_MADD,  32'hFFFF_FFFF, 32'd1, 5, 32'd1, 32'hFFFF_FFFE);
      tick();

      // ops presented while busy are ignored
      drive(0, OP_MULTU, 32'd5, 32'd6);
      tick();
      drive(0, OP_MTHI, 32'hDEAD, 32'd0);
      #1;
      chk("busy stall", {31'b0, stall32}, 32'd1);
      tick();
      drive(0, OP_DIV, 32'd9, 32'd3);
      tick();
      drive(0, OP_NOP, 32'd0, 32'd0);
      n = 0;
      while (busy32 === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      chk("ignore latency", n, 32'd3);
      chk("ignore hi", hi32, 32'd0);
      chk("ignore lo", lo32, 32'd30);
      tick();
      chk("ignore no div", {31'b0, busy32}, 32'd0);

      // flush in busy cycle 10 of a DIV
      drive(0, OP_DIV, 32'd100, 32'd7);
      tick();
      drive(0, OP_NOP, 32'd0, 32'd0);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush busy", {31'b0, busy32}, 32'd0);
      chk("flush done", {31'b0, done32}, 32'd0);
      chk("flush hi", hi32, 32'd0);
      chk("flush lo", lo32, 32'd30);
      seen = 0;
      repeat (40) begin
         tick();
         if (done32 !== 1'b0) seen = 1;
      end
      chk("flush no late done", seen, 32'd0);
      run("mult after flush", 0, OP_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);
      tick();

      // flush on the commit edge suppresses the write
      drive(0, OP_MULT, 32'd7, 32'd7);
      tick();
      drive(0, OP_NOP, 32'd0, 32'd0);
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("cflush busy", {31'b0, busy32}, 32'd0);
      chk("cflush done", {31'b0, done32}, 32'd0);
      chk("cflush lo", lo32, 32'd12);

      // ops coinciding with flush in IDLE are dropped
      flush = 1'b1;
      drive(0, OP_MTLO, 32'd55, 32'd0);
      tick();
      chk("flush drops mtlo", lo32, 32'd12);
      drive(0, OP_MULT, 32'd2, 32'd2);
      tick();
      chk("flush drops mult", {31'b0, busy32}, 32'd0);
      flush = 1'b0;

      // reserved opcode behaves as NOP
      drive(0, 4'd12, 32'd1, 32'd1);
      #1;
      chk("op12 stall", {31'b0, stall32}, 32'd0);
      tick();
      chk("op12 busy", {31'b0, busy32}, 32'd0);
      chk("op12 lo", lo32, 32'd12);

      // reset in the middle of a DIV
      drive(0, OP_MTHI, 32'h77, 32'd0);
      tick();
      drive(0, OP_DIV, 32'd100, 32'd7);
      tick();
      drive(0, OP_NOP, 32'd0, 32'd0);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mreset hi", hi32, 32'd0);
      chk("mreset lo", lo32, 32'd0);
      chk("mreset busy", {31'b0, busy32}, 32'd0);
      run("divu after reset", 0, OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
